// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
// -------------
// Bundles the request/grant signals between the Wishbone masters'
// interconnect and the round-robin arbiter.
//
//   mcyc_i    [MASTERS]  per-master cycle request
//   mstb_i    [MASTERS]  per-master strobe
//   sack_i               acknowledge from the currently muxed slave
//   gnt_o     [MASTERS]  one-hot grant (or zero), registered
//   gnt_idx_o [IDX_W]    binary index of the grant; holds while ungranted
//   busy_o               a grant is active
//   merr_o    [MASTERS]  one-cycle watchdog error, one-hot, registered
//
// Request/grant handshake: a master raises mcyc_i and keeps it high until it
// sees its gnt_o bit; ownership then lasts for as long as that master keeps
// mcyc_i high, and ends at the first edge where it is sampled low. Within an
// owned cycle each mstb_i beat is completed by sack_i (normal termination) or
// by merr_o (watchdog termination, which also ends the ownership).
//
// Modports: "master" is the interconnect/master side that drives requests,
// "slave" is the arbiter side.

interface wb_arbiter_if #(
    parameter int MASTERS = 2
);
    localparam int IDX_W = $clog2(MASTERS);

    logic [MASTERS-1:0] mcyc_i;
    logic [MASTERS-1:0] mstb_i;
    logic               sack_i;
    logic [MASTERS-1:0] gnt_o;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic               busy_o;
    logic [MASTERS-1:0] merr_o;

    modport master (
        output mcyc_i,
        output mstb_i,
        output sack_i,
        input  gnt_o,
        input  gnt_idx_o,
        input  busy_o,
        input  merr_o
    );

    modport slave (
        input  mcyc_i,
        input  mstb_i,
        input  sack_i,
        output gnt_o,
        output gnt_idx_o,
        output busy_o,
        output merr_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter
// ----------
// Round-robin Wishbone bus arbiter with a per-transfer watchdog. A grant is
// held for the whole cyc cycle of the winning master (no preemption). When the
// owner drops cyc, the next requester is granted on the same edge. A strobe
// left unacknowledged for more than TIMEOUT cycles ends the transfer with a
// one-cycle merr_o pulse to the owner.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   bus          wb_arbiter_if.slave (requests in, grant/error out)
//   dbg_state_o  current FSM state (IDLE=0, BUSY=1, ERR=2)
//   dbg_wd_o     current watchdog count
//
// All outputs come straight from registers.

module wb_arbiter #(
    parameter int MASTERS = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wb_arbiter_if.slave        bus,
    output logic [1:0]         dbg_state_o,
    output logic [((TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1)-1:0] dbg_wd_o
);

    localparam int IDX_W = $clog2(MASTERS);
    // A disabled watchdog still keeps a 1-bit counter that never moves.
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic [1:0]         r_state;
    logic [MASTERS-1:0] r_gnt;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [IDX_W-1:0]   r_last;
    logic               r_busy;
    logic [MASTERS-1:0] r_merr;
    logic [WD_W-1:0]    r_wd;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic               w_cyc_g;
    logic               w_stb_g;

    // Round-robin search starting just above r_last: first look at indices
    // above it, then wrap around to indices at or below it. In BUSY r_last
    // equals the current owner, so this also serves the handoff search.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        for (int j = 0; j < MASTERS; j++) begin
            if (!w_found && bus.mcyc_i[j] && (j > int'(r_last))) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(j);
            end
        end
        for (int j = 0; j < MASTERS; j++) begin
            if (!w_found && bus.mcyc_i[j] && (j <= int'(r_last))) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(j);
            end
        end
    end

    // Owner's cyc/stb, selected with the one-hot grant (zero outside BUSY).
    assign w_cyc_g = |(bus.mcyc_i & r_gnt);
    assign w_stb_g = |(bus.mstb_i & r_gnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_last    <= IDX_W'(MASTERS - 1);
            r_busy    <= 1'b0;
            r_merr    <= '0;
            r_wd      <= '0;
        end else begin
            r_merr <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_wd <= '0;
                    if (w_found) begin
                        r_state   <= ST_BUSY;
                        r_gnt     <= MASTERS'(1) << w_pick;
                        r_gnt_idx <= w_pick;
                        r_last    <= w_pick;
                        r_busy    <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!w_cyc_g) begin
                        // Release takes priority over a watchdog expiry.
                        r_wd <= '0;
                        if (w_found) begin
                            r_gnt     <= MASTERS'(1) << w_pick;
                            r_gnt_idx <= w_pick;
                            r_last    <= w_pick;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_stb_g && !bus.sack_i) begin
                        if ((TIMEOUT != 0) && (r_wd == WD_MAX)) begin
                            r_state <= ST_ERR;
                            r_merr  <= r_gnt;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            r_wd    <= '0;
                        end else if (r_wd != WD_MAX) begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end else begin
                        // Ack (wins over expiry) or no strobe: restart the count.
                        r_wd <= '0;
                    end
                end
                ST_ERR: begin
                    // r_last keeps the faulting master, giving it lowest priority.
                    r_state <= ST_IDLE;
                    r_wd    <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_wd    <= '0;
                end
            endcase
        end
    end

    assign bus.gnt_o     = r_gnt;
    assign bus.gnt_idx_o = r_gnt_idx;
    assign bus.busy_o    = r_busy;
    assign bus.merr_o    = r_merr;
    assign dbg_state_o   = r_state;
    assign dbg_wd_o      = r_wd;

endmodule
